axi2apb_apb_master_s5: RTL and testbench

- APB-side engine of the AXI-to-APB bridge.
- Accepts one transfer at a time over a 4-phase REQ/ACK request interface driven by the AXI-side front end.
- Decodes the address onto one of five APB slaves, runs the APB3/APB4 SETUP/ACCESS sequence, and returns read data and error status.

---
 rtl/axi2apb_apb_master_s5_if.sv | 61 ++++++
 rtl/axi2apb_apb_master_s5.sv | 202 ++++++++++++++++++++
 tb/tb_axi2apb_apb_master_s5.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi2apb_apb_master_s5_if.sv
// ---------------------------------------------------------------------------
// axi2apb_apb_master_s5_if
// Bundles the signals of the APB-side bridge engine.
//   Request side (from the AXI front end): REQ/ACK 4-phase handshake,
//   ADDR, WR, DATAW, BE, PROT in; DATAR, ERROR out.
//   APB side: shared PADDR/PENABLE/PWRITE/PWDATA/PSTRB/PPROT, one PSEL per
//   slave, and per-slave PRDATA/PREADY/PSLVERR.
// Modports:
//   master - the bridge engine (drives ACK, DATAR, ERROR and the APB bus).
//   slave  - the environment (requester plus APB slaves).
// ---------------------------------------------------------------------------
interface axi2apb_apb_master_s5_if #(
    parameter int WIDTH_PAD = 32,
    parameter int WIDTH_PDA = 32,
    parameter int WIDTH_PDS = WIDTH_PDA / 8
);
    // Request interface
    logic                 REQ;
    logic                 ACK;
    logic [WIDTH_PAD-1:0] ADDR;
    logic                 WR;
    logic [WIDTH_PDA-1:0] DATAW;
    logic [WIDTH_PDS-1:0] BE;
    logic [2:0]           PROT;
    logic [WIDTH_PDA-1:0] DATAR;
    logic                 ERROR;

    // Shared APB bus
    logic [WIDTH_PAD-1:0] PADDR;
    logic                 PENABLE;
    logic                 PWRITE;
    logic [WIDTH_PDA-1:0] PWDATA;
    logic [WIDTH_PDS-1:0] PSTRB;
    logic [2:0]           PPROT;

    // Per-slave APB signals
    logic                 PSEL_0, PSEL_1, PSEL_2, PSEL_3, PSEL_4;
    logic [WIDTH_PDA-1:0] PRDATA_0, PRDATA_1, PRDATA_2, PRDATA_3, PRDATA_4;
    logic                 PREADY_0, PREADY_1, PREADY_2, PREADY_3, PREADY_4;
    logic                 PSLVERR_0, PSLVERR_1, PSLVERR_2, PSLVERR_3, PSLVERR_4;

    modport master (
        input  REQ, ADDR, WR, DATAW, BE, PROT,
        output ACK, DATAR, ERROR,
        output PADDR, PENABLE, PWRITE, PWDATA, PSTRB, PPROT,
        output PSEL_0, PSEL_1, PSEL_2, PSEL_3, PSEL_4,
        input  PRDATA_0, PRDATA_1, PRDATA_2, PRDATA_3, PRDATA_4,
        input  PREADY_0, PREADY_1, PREADY_2, PREADY_3, PREADY_4,
        input  PSLVERR_0, PSLVERR_1, PSLVERR_2, PSLVERR_3, PSLVERR_4
    );

    modport slave (
        output REQ, ADDR, WR, DATAW, BE, PROT,
        input  ACK, DATAR, ERROR,
        input  PADDR, PENABLE, PWRITE, PWDATA, PSTRB, PPROT,
        input  PSEL_0, PSEL_1, PSEL_2, PSEL_3, PSEL_4,
        output PRDATA_0, PRDATA_1, PRDATA_2, PRDATA_3, PRDATA_4,
        output PREADY_0, PREADY_1, PREADY_2, PREADY_3, PREADY_4,
        output PSLVERR_0, PSLVERR_1, PSLVERR_2, PSLVERR_3, PSLVERR_4
    );
endinterface

// File: rtl/axi2apb_apb_master_s5.sv
// ---------------------------------------------------------------------------
// axi2apb_apb_master_s5
// APB-side engine of the AXI-to-APB bridge. Takes one transfer at a time over
// a 4-phase REQ/ACK handshake, decodes the address onto one of five APB
// slaves, runs SETUP/ACCESS and returns read data plus error status.
// Ports:
//   PCLK   - clock
//   PRESET - asynchronous active-high reset (abandons any transfer)
//   bus    - axi2apb_apb_master_s5_if.master (request side + APB bus)
// Build option:
//   AXI2APB_REQ_SYNC_EN - when defined, REQ passes through a 2-flop
//   synchronizer before use (requester in another clock domain).
// ---------------------------------------------------------------------------
module axi2apb_apb_master_s5 #(
    parameter int                   NUM_PSLAVE    = 5,
    parameter int                   WIDTH_PAD     = 32,
    parameter int                   WIDTH_PDA     = 32,
    parameter int                   WIDTH_PDS     = WIDTH_PDA / 8,
    parameter logic [WIDTH_PAD-1:0] ADDR_PBASE0   = 32'h0000_0000,
    parameter logic [WIDTH_PAD-1:0] ADDR_PBASE1   = 32'h0000_1000,
    parameter logic [WIDTH_PAD-1:0] ADDR_PBASE2   = 32'h0000_2000,
    parameter logic [WIDTH_PAD-1:0] ADDR_PBASE3   = 32'h0000_3000,
    parameter logic [WIDTH_PAD-1:0] ADDR_PBASE4   = 32'h0000_4000,
    parameter int                   ADDR_PLENGTH0 = 12,
    parameter int                   ADDR_PLENGTH1 = 12,
    parameter int                   ADDR_PLENGTH2 = 12,
    parameter int                   ADDR_PLENGTH3 = 12,
    parameter int                   ADDR_PLENGTH4 = 12
) (
    input logic                      PCLK,
    input logic                      PRESET,
    axi2apb_apb_master_s5_if.master  bus
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t               state;
    logic                 req_s;
    logic                 hit;
    logic [2:0]           hit_idx;
    logic [2:0]           sel;
    logic [4:0]           psel;
    logic [4:0]           pready_v;
    logic [4:0]           pslverr_v;
    logic [WIDTH_PDA-1:0] prdata_v [5];

    logic                 ack;
    logic [WIDTH_PDA-1:0] datar;
    logic                 error;
    logic [WIDTH_PAD-1:0] paddr;
    logic                 penable;
    logic                 pwrite;
    logic [WIDTH_PDA-1:0] pwdata;
    logic [WIDTH_PDS-1:0] pstrb;
    logic [2:0]           pprot;

`ifdef AXI2APB_REQ_SYNC_EN
    logic req_meta;
    logic req_sync;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            req_meta <= 1'b0;
            req_sync <= 1'b0;
        end else begin
            req_meta <= bus.REQ;
            req_sync <= req_meta;
        end
    end

    assign req_s = req_sync;
`else
    assign req_s = bus.REQ;
`endif

    function automatic logic [WIDTH_PAD-1:0] base_of(input int i);
        case (i)
            0:       base_of = ADDR_PBASE0;
            1:       base_of = ADDR_PBASE1;
            2:       base_of = ADDR_PBASE2;
            3:       base_of = ADDR_PBASE3;
            4:       base_of = ADDR_PBASE4;
            default: base_of = '0;
        endcase
    endfunction

    function automatic int len_of(input int i);
        case (i)
            0:       len_of = ADDR_PLENGTH0;
            1:       len_of = ADDR_PLENGTH1;
            2:       len_of = ADDR_PLENGTH2;
            3:       len_of = ADDR_PLENGTH3;
            4:       len_of = ADDR_PLENGTH4;
            default: len_of = WIDTH_PAD;
        endcase
    endfunction

    // Scan from the highest index down so that the lowest matching index
    // is the one left standing when regions overlap.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 4; i >= 0; i--) begin
            if (i < NUM_PSLAVE &&
                (((bus.ADDR ^ base_of(i)) >> len_of(i)) == '0)) begin
                hit     = 1'b1;
                hit_idx = 3'(i);
            end
        end
    end

    assign pready_v  = {bus.PREADY_4, bus.PREADY_3, bus.PREADY_2,
                        bus.PREADY_1, bus.PREADY_0};
    assign pslverr_v = {bus.PSLVERR_4, bus.PSLVERR_3, bus.PSLVERR_2,
                        bus.PSLVERR_1, bus.PSLVERR_0};
    assign prdata_v[0] = bus.PRDATA_0;
    assign prdata_v[1] = bus.PRDATA_1;
    assign prdata_v[2] = bus.PRDATA_2;
    assign prdata_v[3] = bus.PRDATA_3;
    assign prdata_v[4] = bus.PRDATA_4;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state   <= IDLE;
            sel     <= '0;
            psel    <= '0;
            ack     <= 1'b0;
            datar   <= '0;
            error   <= 1'b0;
            paddr   <= '0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            pwdata  <= '0;
            pstrb   <= '0;
            pprot   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_s) begin
                        if (hit) begin
                            paddr         <= bus.ADDR;
                            pwrite        <= bus.WR;
                            pwdata        <= bus.DATAW;
                            pstrb         <= bus.WR ? bus.BE : '0;
                            pprot         <= bus.PROT;
                            sel           <= hit_idx;
                            psel          <= '0;
                            psel[hit_idx] <= 1'b1;
                            penable       <= 1'b0;
                            state         <= SETUP;
                        end else begin
                            // Unmapped: complete at once with an error.
                            datar <= '0;
                            error <= 1'b1;
                            ack   <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (pready_v[sel]) begin
                        datar   <= pwrite ? '0 : prdata_v[sel];
                        error   <= pslverr_v[sel];
                        ack     <= 1'b1;
                        psel    <= '0;
                        penable <= 1'b0;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    // ACK stays up until the requester drops REQ, so a REQ
                    // held high cannot launch a second transfer.
                    if (!req_s) begin
                        ack   <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ACK     = ack;
    assign bus.DATAR   = datar;
    assign bus.ERROR   = error;
    assign bus.PADDR   = paddr;
    assign bus.PENABLE = penable;
    assign bus.PWRITE  = pwrite;
    assign bus.PWDATA  = pwdata;
    assign bus.PSTRB   = pstrb;
    assign bus.PPROT   = pprot;
    assign bus.PSEL_0  = psel[0];
    assign bus.PSEL_1  = psel[1];
    assign bus.PSEL_2  = psel[2];
    assign bus.PSEL_3  = psel[3];
    assign bus.PSEL_4  = psel[4];

endmodule

// File: tb/tb_axi2apb_apb_master_s5.sv
// ---------------------------------------------------------------------------
// tb_axi2apb_apb_master_s5
// Directed bench for the APB-side bridge engine: write, wait-state read,
// slave error, strobe/prot write, unmapped address, REQ held after ACK,
// and reset in the middle of ACCESS.
// ---------------------------------------------------------------------------
module tb_axi2apb_apb_master_s5;

`ifdef AXI2APB_REQ_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    logic PCLK;
    logic PRESET;

    int n_tests = 0;
    int n_fail  = 0;
    int psel_cycles = 0;
    int pen_cycles  = 0;

    axi2apb_apb_master_s5_if bus ();

    axi2apb_apb_master_s5 dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Cycle counters for select/enable activity, sampled just after each edge.
    always @(posedge PCLK) begin
        #1;
        if (bus.PSEL_0 | bus.PSEL_1 | bus.PSEL_2 | bus.PSEL_3 | bus.PSEL_4)
            psel_cycles++;
        if (bus.PENABLE)
            pen_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    task automatic clear_slaves();
        bus.PRDATA_0 = '0; bus.PRDATA_1 = '0; bus.PRDATA_2 = '0;
        bus.PRDATA_3 = '0; bus.PRDATA_4 = '0;
        bus.PREADY_0 = 1'b0; bus.PREADY_1 = 1'b0; bus.PREADY_2 = 1'b0;
        bus.PREADY_3 = 1'b0; bus.PREADY_4 = 1'b0;
        bus.PSLVERR_0 = 1'b0; bus.PSLVERR_1 = 1'b0; bus.PSLVERR_2 = 1'b0;
        bus.PSLVERR_3 = 1'b0; bus.PSLVERR_4 = 1'b0;
    endtask

    initial begin
        PRESET   = 1'b1;
        bus.REQ  = 1'b0;
        bus.ADDR = '0;
        bus.WR   = 1'b0;
        bus.DATAW = '0;
        bus.BE   = '0;
        bus.PROT = '0;
        clear_slaves();

        // Reset state
        tick(3);
        check("rst_ack",     32'(bus.ACK), 32'h0);
        check("rst_penable", 32'(bus.PENABLE), 32'h0);
        check("rst_psel",    32'({bus.PSEL_4, bus.PSEL_3, bus.PSEL_2,
                                  bus.PSEL_1, bus.PSEL_0}), 32'h0);
        check("rst_paddr",   bus.PADDR, 32'h0);
        check("rst_datar",   bus.DATAR, 32'h0);
        check("rst_error",   32'(bus.ERROR), 32'h0);
        PRESET = 1'b0;
        tick(1);

        // Zero-wait write to slave 1, then REQ held 5 cycles past ACK
        bus.ADDR = 32'h0000_1004; bus.WR = 1'b1;
        bus.DATAW = 32'hDEAD_BEEF; bus.BE = 4'hF; bus.PROT = 3'b000;
        bus.PREADY_1 = 1'b1;
        psel_cycles = 0;
        bus.REQ = 1'b1;
        tick(SYNC + 1);
        check("wr_setup_psel1",   32'(bus.PSEL_1), 32'h1);
        check("wr_setup_penable", 32'(bus.PENABLE), 32'h0);
        check("wr_setup_paddr",   bus.PADDR, 32'h0000_1004);
        check("wr_setup_pwdata",  bus.PWDATA, 32'hDEAD_BEEF);
        check("wr_setup_pstrb",   32'(bus.PSTRB), 32'hF);
        check("wr_setup_pwrite",  32'(bus.PWRITE), 32'h1);
        check("wr_setup_ack",     32'(bus.ACK), 32'h0);
        tick(1);
        check("wr_access_penable", 32'(bus.PENABLE), 32'h1);
        check("wr_access_psel1",   32'(bus.PSEL_1), 32'h1);
        tick(1);
        check("wr_done_ack",     32'(bus.ACK), 32'h1);
        check("wr_done_error",   32'(bus.ERROR), 32'h0);
        check("wr_done_penable", 32'(bus.PENABLE), 32'h0);
        check("wr_done_psel1",   32'(bus.PSEL_1), 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("hold_req_ack", 32'(bus.ACK), 32'h1);
        end
        check("hold_req_one_xfer", 32'(psel_cycles), 32'd2);
        bus.REQ = 1'b0;
        tick(SYNC);
        check("ack_before_drop", 32'(bus.ACK), 32'h1);
        tick(1);
        check("ack_drop", 32'(bus.ACK), 32'h0);
        bus.PREADY_1 = 1'b0;

        // Read from slave 3 with two wait states
        bus.ADDR = 32'h0000_3008; bus.WR = 1'b0; bus.BE = 4'hF;
        bus.PRDATA_3 = 32'h1234_5678; bus.PREADY_3 = 1'b0;
        pen_cycles = 0;
        bus.REQ = 1'b1;
        tick(SYNC + 1);
        check("rd_setup_psel3",  32'(bus.PSEL_3), 32'h1);
        check("rd_setup_pstrb",  32'(bus.PSTRB), 32'h0);
        check("rd_setup_pwrite", 32'(bus.PWRITE), 32'h0);
        tick(1);
        check("rd_access1_penable", 32'(bus.PENABLE), 32'h1);
        tick(1);
        check("rd_access2_penable", 32'(bus.PENABLE), 32'h1);
        check("rd_access2_ack",     32'(bus.ACK), 32'h0);
        tick(1);
        check("rd_access3_penable", 32'(bus.PENABLE), 32'h1);
        bus.PREADY_3 = 1'b1;
        tick(1);
        check("rd_done_ack",   32'(bus.ACK), 32'h1);
        check("rd_done_datar", bus.DATAR, 32'h1234_5678);
        check("rd_done_error", 32'(bus.ERROR), 32'h0);
        check("rd_pen_cycles", 32'(pen_cycles), 32'd3);
        bus.REQ = 1'b0;
        tick(SYNC + 1);
        check("rd_ack_drop",   32'(bus.ACK), 32'h0);
        check("rd_datar_hold", bus.DATAR, 32'h1234_5678);
        bus.PREADY_3 = 1'b0;

        // Slave error on slave 4
        bus.ADDR = 32'h0000_4000; bus.WR = 1'b0;
        bus.PRDATA_4 = 32'hA5A5_0000; bus.PREADY_4 = 1'b1; bus.PSLVERR_4 = 1'b1;
        bus.REQ = 1'b1;
        tick(SYNC + 3);
        check("err_ack",   32'(bus.ACK), 32'h1);
        check("err_error", 32'(bus.ERROR), 32'h1);
        check("err_datar", bus.DATAR, 32'hA5A5_0000);
        bus.REQ = 1'b0;
        tick(SYNC + 1);
        check("err_ack_drop",   32'(bus.ACK), 32'h0);
        check("err_error_hold", 32'(bus.ERROR), 32'h1);
        clear_slaves();

        // Partial-strobe write with protection bits to slave 0
        bus.ADDR = 32'h0000_0010; bus.WR = 1'b1;
        bus.DATAW = 32'h00C0_FFEE; bus.BE = 4'h3; bus.PROT = 3'b101;
        bus.PREADY_0 = 1'b1;
        bus.REQ = 1'b1;
        tick(SYNC + 1);
        check("wr2_psel0", 32'(bus.PSEL_0), 32'h1);
        check("wr2_pstrb", 32'(bus.PSTRB), 32'h3);
        check("wr2_pprot", 32'(bus.PPROT), 32'h5);
        check("wr2_paddr", bus.PADDR, 32'h0000_0010);
        tick(2);
        check("wr2_ack",   32'(bus.ACK), 32'h1);
        check("wr2_datar", bus.DATAR, 32'h0);
        check("wr2_error", 32'(bus.ERROR), 32'h0);
        bus.REQ = 1'b0;
        tick(SYNC + 1);
        bus.PREADY_0 = 1'b0;

        // Unmapped address
        bus.ADDR = 32'h0000_8000; bus.WR = 1'b0;
        psel_cycles = 0;
        bus.REQ = 1'b1;
        tick(SYNC);
        check("unmap_ack_early", 32'(bus.ACK), 32'h0);
        tick(1);
        check("unmap_ack",   32'(bus.ACK), 32'h1);
        check("unmap_error", 32'(bus.ERROR), 32'h1);
        check("unmap_datar", bus.DATAR, 32'h0);
        tick(2);
        check("unmap_no_psel",    32'(psel_cycles), 32'd0);
        check("idle_paddr_hold",  bus.PADDR, 32'h0000_0010);
        check("idle_pwrite_hold", 32'(bus.PWRITE), 32'h1);
        bus.REQ = 1'b0;
        tick(SYNC + 1);
        check("unmap_ack_drop", 32'(bus.ACK), 32'h0);

        // Reset in the middle of ACCESS on slave 2
        bus.ADDR = 32'h0000_2000; bus.WR = 1'b0; bus.PREADY_2 = 1'b0;
        bus.REQ = 1'b1;
        tick(SYNC + 2);
        check("mid_penable", 32'(bus.PENABLE), 32'h1);
        check("mid_psel2",   32'(bus.PSEL_2), 32'h1);
        PRESET = 1'b1;
        #1;
        check("arst_penable", 32'(bus.PENABLE), 32'h0);
        check("arst_psel2",   32'(bus.PSEL_2), 32'h0);
        check("arst_paddr",   bus.PADDR, 32'h0);
        check("arst_pwrite",  32'(bus.PWRITE), 32'h0);
        check("arst_error",   32'(bus.ERROR), 32'h0);
        bus.REQ = 1'b0;
        bus.PREADY_2 = 1'b1;
        bus.PRDATA_2 = 32'h0BAD_F00D;
        tick(1);
        PRESET = 1'b0;
        psel_cycles = 0;
        tick(6);
        check("post_rst_no_ack",  32'(bus.ACK), 32'h0);
        check("post_rst_no_psel", 32'(psel_cycles), 32'd0);
        bus.REQ = 1'b1;
        tick(SYNC + 3);
        check("post_rst_rd_ack",   32'(bus.ACK), 32'h1);
        check("post_rst_rd_datar", bus.DATAR, 32'h0BAD_F00D);
        bus.REQ = 1'b0;
        tick(SYNC + 1);
        check("post_rst_ack_drop", 32'(bus.ACK), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
